dbg_prog_loader: RTL and testbench

//  Debug program loader for cpuCore. Accepts (address, instruction) words from a host/bench over a

---
 rtl/dbg_prog_loader.sv | 162 ++++++++++++++++
 tb/tb_dbg_prog_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_prog_loader.sv
// Debug program loader: buffers host (addr, instr) words in a FIFO and streams them into
// instruction memory, holding the core in reset until a start command drains the buffer.
module dbg_prog_loader #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 4,
   parameter int ADDR_STEP  = 4,
   parameter int RESET_HOLD = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             host_valid,
   output logic             host_ready,
   input  logic             host_auto,
   input  logic [XLEN-1:0]  host_addr,
   input  logic [XLEN-1:0]  host_instr,
   input  logic             host_start,
   input  logic             host_halt,
   output logic             imem_wr_en,
   input  logic             imem_ready,
   output logic [XLEN-1:0]  imem_addr,
   output logic [XLEN-1:0]  imem_wdata,
   output logic             core_rst,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] load_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(RESET_HOLD) + 1;

   typedef enum logic [1:0] {
      S_LOAD,
      S_DRAIN,
      S_HOLD,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]  ptr_q, ptr_d;
   logic             wr_en_q, wr_en_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic             core_rst_q, core_rst_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] load_cnt_q, load_cnt_d;

   logic [XLEN-1:0]  fifo_addr [DEPTH];
   logic [XLEN-1:0]  fifo_data [DEPTH];

   logic             empty, full, accept, aligned, push, pop, done;
   logic [XLEN-1:0]  acc_addr;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign acc_addr = host_auto ? ptr_q : host_addr;
   assign aligned  = (acc_addr[1:0] == 2'b00);
   assign accept   = host_valid & host_ready;
   assign push     = accept & aligned;
   assign done     = wr_en_q & imem_ready;
   // No bypass: a word always sits in the FIFO for one edge before the port.
   assign pop      = !empty && (!wr_en_q || imem_ready);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      err_d    = err_q;
      if (accept) begin
         if (aligned) ptr_d = acc_addr + XLEN'(ADDR_STEP);
         else         err_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_comb begin
      wr_en_d = wr_en_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (!wr_en_q || imem_ready) begin
         wr_en_d = !empty;
         if (!empty) begin
            addr_d  = fifo_addr[rd_ptr_q];
            wdata_d = fifo_data[rd_ptr_q];
         end
      end
      load_cnt_d = load_cnt_q;
      if (done && load_cnt_q != '1) load_cnt_d = load_cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_LOAD:  if (host_start) state_d = S_DRAIN;
         S_DRAIN: if (empty && !wr_en_q) begin
            state_d = S_HOLD;
            hold_d  = '0;
         end
         S_HOLD:  if (hold_q == HW'(RESET_HOLD - 1)) state_d = S_RUN;
                  else hold_d = hold_q + HW'(1);
         default: ;
      endcase
      if (host_halt) state_d = S_LOAD;
      core_rst_d = (state_d != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q] <= acc_addr;
         fifo_data[wr_ptr_q] <= host_instr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOAD;
         hold_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ptr_q      <= '0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
         err_q      <= 1'b0;
         load_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
         err_q      <= err_d;
         load_cnt_q <= load_cnt_d;
      end
   end

   assign host_ready = (state_q == S_LOAD) && !full;
   assign imem_wr_en = wr_en_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign core_rst   = core_rst_q;
   assign busy       = !empty || wr_en_q;
   assign err        = err_q;
   assign load_count = load_cnt_q;

endmodule

// File: tb/tb_dbg_prog_loader.sv
// Scoreboard bench for dbg_prog_loader: directed loads, stalls, auto-increment, errors,
// run/halt control and reset abort.
module tb_dbg_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        host_valid = 1'b0;
   logic        host_ready;
   logic        host_auto = 1'b0;
   logic [31:0] host_addr = '0;
   logic [31:0] host_instr = '0;
   logic        host_start = 1'b0;
   logic        host_halt = 1'b0;
   logic        imem_wr_en;
   logic        imem_ready = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        busy;
   logic        err;
   logic [15:0] load_count;

   dbg_prog_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_auto  (host_auto),
      .host_addr  (host_addr),
      .host_instr (host_instr),
      .host_start (host_start),
      .host_halt  (host_halt),
      .imem_wr_en (imem_wr_en),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .err        (err),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [31:0] got,
                                 input logic [31:0] expv);
      total_cnt++;
      if (got === expv) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h", nm, got, expv);
   endfunction

   // Monitor: every completed write must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && imem_wr_en && imem_ready) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write got=%h exp=none", imem_addr);
         end else begin
            e = sb.pop_front();
            check("wr_addr", imem_addr, e.a);
            check("wr_data", imem_wdata, e.d);
            if (e.lat) check("wr_latency", 32'(cyc + 1 - e.acc), 32'd2);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic au, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_a, input bit ok, input bit lat);
      int n = 0;
      bit got = 0;
      host_valid = 1'b1;
      host_auto  = au;
      host_addr  = a;
      host_instr = d;
      while (!got && n < 60) begin
         @(negedge clk);
         if (host_ready) got = 1;
         n++;
      end
      if (!got) begin
         total_cnt++;
         $display("FAIL push_timeout got=%h exp=accepted", a);
      end else if (ok) begin
         sb.push_back('{exp_a, d, cyc + 1, lat});
      end
      @(posedge clk);
      #1;
      host_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total_cnt++;
         $display("FAIL idle_timeout got=busy exp=idle");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      host_start = 1'b1;
      tick(1);
      host_start = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("rst_core_rst", core_rst, 1);
      check("rst_wr_en", imem_wr_en, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_host_ready", host_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_load_count", load_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // basic load, then start -> drain -> hold -> run
      imem_ready = 1'b1;
      push(0, 32'd4,  32'h00C00093, 32'd4,  1, 1);
      push(0, 32'd8,  32'h00200113, 32'd8,  1, 1);
      push(0, 32'd24, 32'h4020D1B3, 32'd24, 1, 1);
      wait_idle();
      check("t1_load_count", load_count, 3);
      pulse_start();
      check("t1_drain_ready", host_ready, 0);
      check("t1_drain_rst", core_rst, 1);
      tick(2);
      check("t1_hold_rst", core_rst, 1);
      tick(1);
      check("t1_run_rst", core_rst, 0);
      check("t1_run_ready", host_ready, 0);

      // halt in RUN, then start+halt together
      host_halt = 1'b1;
      tick(1);
      host_halt = 1'b0;
      check("t5_halt_rst", core_rst, 1);
      check("t5_halt_ready", host_ready, 1);
      host_start = 1'b1;
      host_halt  = 1'b1;
      tick(1);
      host_start = 1'b0;
      host_halt  = 1'b0;
      check("t5_both_ready", host_ready, 1);
      tick(4);
      check("t5_both_rst", core_rst, 1);
      check("t5_both_ready2", host_ready, 1);

      // stalled memory fills the buffer
      imem_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(0, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i),
              32'h100 + 32'(4 * i), 1, 0);
      check("t2_full_ready", host_ready, 0);
      check("t2_stall_wr_en", imem_wr_en, 1);
      check("t2_stall_addr", imem_addr, 32'h100);
      check("t2_stall_data", imem_wdata, 32'hA000_0000);
      tick(3);
      check("t2_hold_addr", imem_addr, 32'h100);
      check("t2_hold_data", imem_wdata, 32'hA000_0000);
      check("t2_hold_count", load_count, 3);
      imem_ready = 1'b1;
      push(0, 32'h114, 32'hA000_0005, 32'h114, 1, 0);
      wait_idle();
      check("t2_load_count", load_count, 9);

      // auto-increment and wrap
      apply_reset();
      for (int i = 0; i < 6; i++)
         push(1, 32'hDEAD_0000, 32'hB000_0000 + 32'(i), 32'(4 * i), 1, 1);
      push(0, 32'hFFFF_FFFC, 32'hC000_0001, 32'hFFFF_FFFC, 1, 1);
      push(1, 32'h0000_1234, 32'hC000_0002, 32'h0000_0000, 1, 1);
      wait_idle();
      check("t3_load_count", load_count, 8);

      // misaligned word is dropped
      push(0, 32'd6, 32'hDEAD_BEEF, 32'd6, 0, 0);
      check("t4_err", err, 1);
      tick(4);
      check("t4_count_same", load_count, 8);
      check("t4_busy", busy, 0);
      push(0, 32'h40, 32'h1234_5678, 32'h40, 1, 1);
      wait_idle();
      check("t4_load_count", load_count, 9);
      check("t4_err_sticky", err, 1);

      // reset aborts a pending write in DRAIN
      imem_ready = 1'b0;
      push(0, 32'h200, 32'h5555_AAAA, 32'h200, 1, 0);
      tick(1);
      pulse_start();
      check("t6_wr_en", imem_wr_en, 1);
      check("t6_drain_rst", core_rst, 1);
      check("t6_drain_ready", host_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_abort_wr_en", imem_wr_en, 0);
      check("t6_abort_rst", core_rst, 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      check("t6_busy", busy, 0);
      check("t6_err", err, 0);
      check("t6_load_count", load_count, 0);
      imem_ready = 1'b1;
      tick(4);
      check("t6_no_write", load_count, 0);
      check("sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
